// File: rtl/rng_pkg.sv
// Shared types and default sizing for the RNG bit collector.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } rng_state_e;

    localparam int RNG_WIDTH_DEF     = 8;
    localparam int RNG_RUN_LIMIT_DEF = 32;

endpackage

// File: rtl/rng_debias.sv
// Von Neumann pair extractor: 01 -> 0, 10 -> 1, 00/11 -> nothing.
// Output valid is combinational on the second bit of a pair; no backpressure.
module rng_debias (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic in_vld_i,
    input  logic in_bit_i,
    output logic out_vld_o,
    output logic out_bit_o
);

    logic have_q, have_d;
    logic first_q, first_d;

    always_comb begin
        have_d    = have_q;
        first_d   = first_q;
        out_vld_o = 1'b0;
        out_bit_o = first_q;
        if (flush_i) begin
            have_d  = 1'b0;
            first_d = 1'b0;
        end else if (in_vld_i) begin
            if (!have_q) begin
                have_d  = 1'b1;
                first_d = in_bit_i;
            end else begin
                have_d    = 1'b0;
                first_d   = 1'b0;
                out_vld_o = first_q ^ in_bit_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            have_q  <= have_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/rng_bit_collector.sv
// Assembles raw RNG bits into WIDTH-bit words (valid one edge after the completing bit),
// holds one word under backpressure, flags overrun/stuck source. RNG_DEBIAS_EN adds von Neumann debias.
module rng_bit_collector
    import rng_pkg::*;
#(
    parameter int WIDTH     = RNG_WIDTH_DEF,
    parameter int RUN_LIMIT = RNG_RUN_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             overrun_o,
    output logic             stuck_o,
    input  logic             clear_i
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RUN_LIMIT + 1);

    rng_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d, ovr_set;
    logic             stk_q, stk_d, stk_set;
    logic [RW-1:0]    run_q, run_d;
    logic             last_q, last_d;
    logic             acc, feed, col_vld, col_bit;

    assign acc  = enable_i & bit_valid_i;
    // Bits arriving while a completed word is parked are lost, so they never reach the assembler.
    assign feed = acc & (state_q != ST_FULL);

`ifdef RNG_DEBIAS_EN
    rng_debias u_debias (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (!enable_i || (state_q == ST_FULL)),
        .in_vld_i  (feed),
        .in_bit_i  (bit_i),
        .out_vld_o (col_vld),
        .out_bit_o (col_bit)
    );
`else
    assign col_vld = feed;
    assign col_bit = bit_i;
`endif

    always_comb begin
        run_d   = run_q;
        last_d  = last_q;
        stk_set = 1'b0;
        if (acc) begin
            last_d = bit_i;
            if (clear_i || (run_q == '0) || (bit_i != last_q)) begin
                run_d = RW'(1);
            end else if (run_q != RW'(RUN_LIMIT)) begin
                run_d = run_q + 1'b1;
            end
            stk_set = (run_d == RW'(RUN_LIMIT));
        end else if (clear_i) begin
            run_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        vld_d   = vld_q;
        ovr_set = 1'b0;
        if (vld_q && word_ready_i) begin
            vld_d = 1'b0;
        end
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    state_d = ST_COLLECT;
                    if (col_vld) begin
                        shift_d = {shift_q[WIDTH-2:0], col_bit};
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            if (!vld_q || word_ready_i) begin
                                word_d = shift_d;
                                vld_d  = 1'b1;
                                cnt_d  = '0;
                            end else begin
                                state_d = ST_FULL;
                                cnt_d   = CW'(WIDTH);
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    ovr_set = acc;
                    if (word_ready_i) begin
                        word_d  = shift_q;
                        vld_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ovr_d = ovr_set ? 1'b1 : (clear_i ? 1'b0 : ovr_q);
    assign stk_d = stk_set ? 1'b1 : (clear_i ? 1'b0 : stk_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            stk_q   <= 1'b0;
            run_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            stk_q   <= stk_d;
            run_q   <= run_d;
            last_q  <= last_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = vld_q;
    assign overrun_o    = ovr_q;
    assign stuck_o      = stk_q;

endmodule
